// File: rtl/interrupt_request_resolver.sv
// interrupt_request_resolver
// Request side of an 8259-style interrupt controller. It captures IRQ0-7
// into the IRR and applies the mask. It picks the rotating-priority winner,
// gates that winner against the current ISR for nesting, raises INT, and
// runs the two-pulse INTA handshake.
module interrupt_request_resolver #(
   parameter int VECTOR_BASE_W = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               interrupt_request,
   input  logic                     level_or_edge_triggered,
   input  logic [7:0]               interrupt_mask,
   input  logic [7:0]               in_service_interrupt,
   input  logic                     interrupt_acknowledge,
   input  logic                     auto_rotate,
   input  logic                     rotate_priority,
   input  logic [2:0]               rotate_level,
   input  logic [VECTOR_BASE_W-1:0] vector_base,
   output logic                     interrupt,
   output logic [7:0]               set_in_service,
   output logic [VECTOR_BASE_W+2:0] interrupt_vector,
   output logic                     vector_valid,
   output logic [7:0]               interrupt_request_register
);

   localparam logic [1:0] STATE_IDLE    = 2'd0;
   localparam logic [1:0] STATE_PENDING = 2'd1;
   localparam logic [1:0] STATE_ACK1    = 2'd2;

   logic [1:0]               state_reg;
   logic [7:0]               irr_reg;
   logic [7:0]               prev_reg;
   logic [2:0]               lowest_reg;
   logic [2:0]               id_reg;
   logic                     holdoff_reg;
   logic                     interrupt_reg;
   logic [7:0]               set_in_service_reg;
   logic [VECTOR_BASE_W+2:0] vector_reg;
   logic                     vector_valid_reg;

   logic [7:0] pending;
   logic [7:0] rot_pending;
   logic [7:0] rot_isr;
   logic       win_found;
   logic [2:0] win_rank;
   logic       isr_found;
   logic [2:0] isr_rank;
   logic [2:0] winner;
   logic       eligible;
   logic       ack_real;
   logic [7:0] irr_clear;
   logic [7:0] irr_capture;
   logic [7:0] irr_next;

   assign pending = irr_reg & ~interrupt_mask;

   // Rotate request and in-service vectors so that bit 0 is the current
   // highest priority (lowest_reg + 1) and bit 7 is the lowest.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         localparam logic [2:0] OFFSET = 3'(gi + 1);
         logic [2:0] slot;
         assign slot            = lowest_reg + OFFSET;
         assign rot_pending[gi] = pending[slot];
         assign rot_isr[gi]     = in_service_interrupt[slot];
      end
   endgenerate

   // Priority encode both rotated vectors; a smaller rank means higher priority.
   always_comb begin
      win_found = 1'b0;
      win_rank  = 3'd0;
      isr_found = 1'b0;
      isr_rank  = 3'd0;
      for (int r = 7; r >= 0; r--) begin
         if (rot_pending[r]) begin
            win_found = 1'b1;
            win_rank  = 3'(r);
         end
         if (rot_isr[r]) begin
            isr_found = 1'b1;
            isr_rank  = 3'(r);
         end
      end
      winner   = lowest_reg + win_rank + 3'd1;
      // Nesting: only a strictly higher-priority request may interrupt service.
      eligible = win_found && (!isr_found || (win_rank < isr_rank));
   end

   // The IRR update uses edge or level capture. Clearing the acknowledged
   // bit overrides a simultaneous capture on that bit.
   always_comb begin
      ack_real    = (state_reg == STATE_PENDING) && interrupt_acknowledge && eligible;
      irr_clear   = ack_real ? (8'd1 << winner) : 8'd0;
      irr_capture = level_or_edge_triggered ? interrupt_request
                                            : (irr_reg | (interrupt_request & ~prev_reg));
      irr_next    = irr_capture & ~irr_clear;
   end

   // State, IRR, priority pointer and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg          <= STATE_IDLE;
         irr_reg            <= 8'd0;
         prev_reg           <= 8'd0;
         lowest_reg         <= 3'd7;
         id_reg             <= 3'd0;
         holdoff_reg        <= 1'b0;
         interrupt_reg      <= 1'b0;
         set_in_service_reg <= 8'd0;
         vector_reg         <= '0;
         vector_valid_reg   <= 1'b0;
      end else begin
         prev_reg           <= interrupt_request;
         irr_reg            <= irr_next;
         set_in_service_reg <= 8'd0;
         vector_valid_reg   <= 1'b0;
         vector_reg         <= '0;

         // An explicit rotate command takes precedence over auto-rotation.
         if (rotate_priority) begin
            lowest_reg <= rotate_level;
         end else if (auto_rotate && ack_real) begin
            lowest_reg <= winner;
         end

         case (state_reg)
            STATE_IDLE: begin
               // One idle cycle after a handshake so the ISR update settles.
               if (holdoff_reg) begin
                  holdoff_reg <= 1'b0;
               end else if (eligible) begin
                  state_reg     <= STATE_PENDING;
                  interrupt_reg <= 1'b1;
               end
            end
            STATE_PENDING: begin
               if (interrupt_acknowledge) begin
                  interrupt_reg <= 1'b0;
                  state_reg     <= STATE_ACK1;
                  if (eligible) begin
                     id_reg             <= winner;
                     set_in_service_reg <= 8'd1 << winner;
                  end else begin
                     // Spurious acknowledge reports level 7 and sets nothing.
                     id_reg <= 3'd7;
                  end
               end else if (!eligible) begin
                  interrupt_reg <= 1'b0;
                  state_reg     <= STATE_IDLE;
               end
            end
            STATE_ACK1: begin
               if (interrupt_acknowledge) begin
                  vector_valid_reg <= 1'b1;
                  vector_reg       <= {vector_base, id_reg};
                  state_reg        <= STATE_IDLE;
                  holdoff_reg      <= 1'b1;
               end
            end
            default: begin
               state_reg     <= STATE_IDLE;
               interrupt_reg <= 1'b0;
            end
         endcase
      end
   end

   assign interrupt                  = interrupt_reg;
   assign set_in_service             = set_in_service_reg;
   assign interrupt_vector           = vector_reg;
   assign vector_valid               = vector_valid_reg;
   assign interrupt_request_register = irr_reg;

endmodule

// File: tb/tb_interrupt_request_resolver.sv
// Directed testbench for interrupt_request_resolver.
module tb_interrupt_request_resolver;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] interrupt_request = 8'd0;
   logic       level_or_edge_triggered = 1'b0;
   logic [7:0] interrupt_mask = 8'd0;
   logic [7:0] in_service_interrupt = 8'd0;
   logic       interrupt_acknowledge = 1'b0;
   logic       auto_rotate = 1'b0;
   logic       rotate_priority = 1'b0;
   logic [2:0] rotate_level = 3'd0;
   logic [4:0] vector_base = 5'b01000;
   logic       interrupt;
   logic [7:0] set_in_service;
   logic [7:0] interrupt_vector;
   logic       vector_valid;
   logic [7:0] interrupt_request_register;

   int checks = 0;
   int errors = 0;

   interrupt_request_resolver #(.VECTOR_BASE_W(5)) dut (
      .clock                      (clock),
      .reset                      (reset),
      .interrupt_request          (interrupt_request),
      .level_or_edge_triggered    (level_or_edge_triggered),
      .interrupt_mask             (interrupt_mask),
      .in_service_interrupt       (in_service_interrupt),
      .interrupt_acknowledge      (interrupt_acknowledge),
      .auto_rotate                (auto_rotate),
      .rotate_priority            (rotate_priority),
      .rotate_level               (rotate_level),
      .vector_base                (vector_base),
      .interrupt                  (interrupt),
      .set_in_service             (set_in_service),
      .interrupt_vector           (interrupt_vector),
      .vector_valid               (vector_valid),
      .interrupt_request_register (interrupt_request_register)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      interrupt_request = 8'd0;
      interrupt_acknowledge = 1'b0;
      interrupt_mask = 8'd0;
      in_service_interrupt = 8'd0;
      auto_rotate = 1'b0;
      rotate_priority = 1'b0;
      level_or_edge_triggered = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic pulse_inta();
      interrupt_acknowledge = 1'b1;
      tick();
      interrupt_acknowledge = 1'b0;
   endtask

   // Bounded wait for INT; an expired bound is a failed check.
   task automatic wait_int(input string name);
      int n;
      n = 0;
      while (interrupt !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (interrupt !== 1'b1) begin
         $display("FAIL %s: interrupt not seen within 20 cycles (got %b expected 1)", name, interrupt);
         errors++;
      end else
         $display("txn %s: interrupt asserted", name);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      interrupt_request = 8'hFF;
      level_or_edge_triggered = 1'b1;
      tick();
      tick();
      checks++; if (interrupt !== 1'b0) begin $display("FAIL reset_int: got %b expected 0", interrupt); errors++; end
      checks++; if (set_in_service !== 8'h00) begin $display("FAIL reset_sis: got %h expected 00", set_in_service); errors++; end
      checks++; if (vector_valid !== 1'b0) begin $display("FAIL reset_vv: got %b expected 0", vector_valid); errors++; end
      checks++; if (interrupt_vector !== 8'h00) begin $display("FAIL reset_vec: got %h expected 00", interrupt_vector); errors++; end
      checks++; if (interrupt_request_register !== 8'h00) begin $display("FAIL reset_irr: got %h expected 00", interrupt_request_register); errors++; end
      reset = 1'b1;
      tick();
      checks++; if (interrupt_request_register !== 8'hFF) begin $display("FAIL reset_irr_after: got %h expected ff", interrupt_request_register); errors++; end
      checks++; if (interrupt !== 1'b0) begin $display("FAIL reset_int_early: got %b expected 0", interrupt); errors++; end
      tick();
      checks++; if (interrupt !== 1'b1) begin $display("FAIL reset_int_latency: got %b expected 1", interrupt); errors++; end
      $display("txn reset: irr=%h int=%b", interrupt_request_register, interrupt);
   endtask

   task automatic test_simple_edge();
      apply_reset();
      vector_base = 5'b01000;
      interrupt_request = 8'h08;
      tick();
      checks++; if (interrupt_request_register !== 8'h08) begin $display("FAIL edge_irr_set: got %h expected 08", interrupt_request_register); errors++; end
      checks++; if (interrupt !== 1'b0) begin $display("FAIL edge_int_early: got %b expected 0", interrupt); errors++; end
      tick();
      checks++; if (interrupt !== 1'b1) begin $display("FAIL edge_int: got %b expected 1", interrupt); errors++; end
      pulse_inta();
      checks++; if (set_in_service !== 8'h08) begin $display("FAIL edge_sis: got %h expected 08", set_in_service); errors++; end
      checks++; if (interrupt_request_register !== 8'h00) begin $display("FAIL edge_irr_clr: got %h expected 00", interrupt_request_register); errors++; end
      checks++; if (interrupt !== 1'b0) begin $display("FAIL edge_int_drop: got %b expected 0", interrupt); errors++; end
      tick();
      checks++; if (set_in_service !== 8'h00) begin $display("FAIL edge_sis_pulse: got %h expected 00", set_in_service); errors++; end
      pulse_inta();
      checks++; if (vector_valid !== 1'b1) begin $display("FAIL edge_vv: got %b expected 1", vector_valid); errors++; end
      checks++; if (interrupt_vector !== 8'h43) begin $display("FAIL edge_vec: got %h expected 43", interrupt_vector); errors++; end
      tick();
      checks++; if (vector_valid !== 1'b0) begin $display("FAIL edge_vv_pulse: got %b expected 0", vector_valid); errors++; end
      $display("txn simple_edge: vector 43 handshake done");
   endtask

   task automatic test_priority_nesting();
      apply_reset();
      level_or_edge_triggered = 1'b1;
      interrupt_request = 8'b0010_0110;
      in_service_interrupt = 8'b0000_0100;
      wait_int("nest_int");
      pulse_inta();
      checks++; if (set_in_service !== 8'b0000_0010) begin $display("FAIL nest_sis: got %b expected 00000010", set_in_service); errors++; end
      pulse_inta();
      checks++; if (interrupt_vector !== 8'h41 || vector_valid !== 1'b1) begin $display("FAIL nest_vec: got %h/%b expected 41/1", interrupt_vector, vector_valid); errors++; end
      in_service_interrupt = 8'b0000_0001;
      interrupt_request = 8'b0010_0000;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (interrupt !== 1'b0) begin $display("FAIL nest_blocked: got %b expected 0", interrupt); errors++; end
      checks++; if (interrupt_request_register !== 8'h20) begin $display("FAIL nest_irr: got %h expected 20", interrupt_request_register); errors++; end
      $display("txn priority_nesting: IR1 granted, IR5 blocked by ISR0");
   endtask

   task automatic test_rotation();
      apply_reset();
      level_or_edge_triggered = 1'b1;
      interrupt_request = 8'b0001_0100;
      rotate_priority = 1'b1;
      rotate_level = 3'd3;
      tick();
      rotate_priority = 1'b0;
      wait_int("rot_int");
      pulse_inta();
      checks++; if (set_in_service !== 8'b0001_0000) begin $display("FAIL rot_sis: got %b expected 00010000", set_in_service); errors++; end
      pulse_inta();
      checks++; if (interrupt_vector !== 8'h44) begin $display("FAIL rot_vec: got %h expected 44", interrupt_vector); errors++; end
      rotate_priority = 1'b1;
      rotate_level = 3'd3;
      tick();
      rotate_priority = 1'b0;
      wait_int("auto_int");
      auto_rotate = 1'b1;
      pulse_inta();
      auto_rotate = 1'b0;
      checks++; if (set_in_service !== 8'b0001_0000) begin $display("FAIL auto_sis: got %b expected 00010000", set_in_service); errors++; end
      pulse_inta();
      checks++; if (interrupt_vector !== 8'h44) begin $display("FAIL auto_vec: got %h expected 44", interrupt_vector); errors++; end
      wait_int("auto_next_int");
      pulse_inta();
      checks++; if (set_in_service !== 8'b0000_0100) begin $display("FAIL auto_next_sis: got %b expected 00000100", set_in_service); errors++; end
      pulse_inta();
      checks++; if (interrupt_vector !== 8'h42) begin $display("FAIL auto_next_vec: got %h expected 42", interrupt_vector); errors++; end
      $display("txn rotation: IR4 then IR2 after auto-rotate");
   endtask

   task automatic test_spurious();
      apply_reset();
      level_or_edge_triggered = 1'b1;
      interrupt_request = 8'h40;
      wait_int("spur_int");
      interrupt_request = 8'h00;
      tick();
      pulse_inta();
      checks++; if (set_in_service !== 8'h00) begin $display("FAIL spur_sis: got %h expected 00", set_in_service); errors++; end
      checks++; if (interrupt !== 1'b0) begin $display("FAIL spur_int: got %b expected 0", interrupt); errors++; end
      pulse_inta();
      checks++; if (vector_valid !== 1'b1 || interrupt_vector !== 8'h47) begin $display("FAIL spur_vec: got %h/%b expected 47/1", interrupt_vector, vector_valid); errors++; end
      $display("txn spurious: vector %h", interrupt_vector);
   endtask

   task automatic test_mask_midreset();
      apply_reset();
      interrupt_mask = 8'h08;
      interrupt_request = 8'h08;
      tick();
      tick();
      tick();
      checks++; if (interrupt !== 1'b0) begin $display("FAIL mask_int: got %b expected 0", interrupt); errors++; end
      checks++; if (interrupt_request_register !== 8'h08) begin $display("FAIL mask_irr: got %h expected 08", interrupt_request_register); errors++; end
      interrupt_mask = 8'h00;
      wait_int("unmask_int");
      pulse_inta();
      checks++; if (set_in_service !== 8'h08) begin $display("FAIL unmask_sis: got %h expected 08", set_in_service); errors++; end
      reset = 1'b0;
      tick();
      checks++; if (vector_valid !== 1'b0 || interrupt !== 1'b0) begin $display("FAIL midreset_out: got vv=%b int=%b expected 0/0", vector_valid, interrupt); errors++; end
      reset = 1'b1;
      pulse_inta();
      checks++; if (vector_valid !== 1'b0) begin $display("FAIL midreset_vv: got %b expected 0", vector_valid); errors++; end
      checks++; if (interrupt_request_register !== 8'h08) begin $display("FAIL midreset_irr: got %h expected 08", interrupt_request_register); errors++; end
      tick();
      checks++; if (interrupt !== 1'b1) begin $display("FAIL midreset_idle: got %b expected 1", interrupt); errors++; end
      $display("txn mask_midreset: handshake abandoned, new request raised");
   endtask

   initial begin
      test_reset();
      test_simple_edge();
      test_priority_nesting();
      test_rotation();
      test_spurious();
      test_mask_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
